// File: rtl/system_0_led_pwm_driver.sv
// LEDG pin driver: per-frame PWM brightness and optional blinking over a small Avalon-MM slave.
// Optional macro LED_PWM_GAMMA_EN applies a squared brightness curve to the effective duty.
module system_0_led_pwm_driver #(
  parameter int PRESCALE = 50,
  parameter int BLINK_W  = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  led_in,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [7:0]  led_out
);

  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

  logic [1:0]         ctrl;
  logic [7:0]         duty;
  logic [BLINK_W-1:0] blink_period;
  logic               en;
  logic               blink_en;
  logic               wr;
  logic               unused_wdata;

  logic [PRE_W-1:0]   pre_cnt;
  logic [7:0]         pwm_cnt;
  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_phase;
  logic [7:0]         duty_act;
  logic [7:0]         eff_duty;
  logic               tick;
  logic               frame_start;
  logic               pwm_on;
  logic               gate;

  assign en           = ctrl[0];
  assign blink_en     = ctrl[1];
  assign wr           = chipselect && !write_n;
  assign unused_wdata = ^writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl         <= 2'b00;
      duty         <= 8'hFF;
      blink_period <= '0;
    end else if (wr) begin
      case (address)
        2'd0:    ctrl         <= writedata[1:0];
        2'd1:    duty         <= writedata[7:0];
        2'd2:    blink_period <= writedata[BLINK_W-1:0];
        default: ;
      endcase
    end
  end

`ifdef LED_PWM_GAMMA_EN
  // Upper byte of the square; full scale stays full scale so "always on" survives the curve.
  assign eff_duty = (duty == 8'hFF) ? 8'hFF : 8'((16'(duty) * 16'(duty)) >> 8);
`else
  assign eff_duty = duty;
`endif

  assign tick        = en && (pre_cnt == PRE_LAST);
  assign frame_start = tick && (pwm_cnt == 8'hFF);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_cnt <= '0;
      pwm_cnt <= 8'h00;
    end else if (!en) begin
      pre_cnt <= '0;
      pwm_cnt <= 8'h00;
    end else if (tick) begin
      pre_cnt <= '0;
      pwm_cnt <= pwm_cnt + 8'h01;
    end else begin
      pre_cnt <= pre_cnt + PRE_W'(1);
    end
  end

  // Duty only changes at frame boundaries so a frame never glitches; while idle it tracks DUTY.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      duty_act <= 8'hFF;
    else if (!en || frame_start)
      duty_act <= eff_duty;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if ((wr && address == 2'd2) || !en) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (frame_start) begin
      if (blink_period == '0) begin
        blink_cnt   <= '0;
        blink_phase <= 1'b1;
      end else if (blink_cnt == blink_period - BLINK_W'(1)) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + BLINK_W'(1);
      end
    end
  end

  assign pwm_on = (duty_act == 8'hFF) ? 1'b1 : (pwm_cnt < duty_act);
  assign gate   = pwm_on && (blink_phase || !blink_en);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      led_out <= 8'h00;
    else
      led_out <= en ? (led_in & {8{gate}}) : 8'h00;
  end

  always_comb begin
    readdata = 32'h0;
    case (address)
      2'd0:    readdata = {30'h0, ctrl};
      2'd1:    readdata = {24'h0, duty};
      2'd2:    readdata = 32'(blink_period);
      default: readdata = {23'h0, blink_phase, pwm_cnt};
    endcase
  end

endmodule
